// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer driving one external 1-bit ALU slice, LSB first.
// Rev 1.0 - initial release.
`default_nettype none

module alu_serial_ctrl #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [3:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout,
    input  logic             slice_set
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             carry_q;
    logic             set_msb_q;
    logic             ovf_q;
    logic [WIDTH-1:0] result_nx;
    logic             ovf_now;
    logic             ovf_final;
    logic             is_last;

    assign is_last   = (state == S_RUN) && (idx == LAST_IDX);
    assign ovf_now   = carry_q ^ slice_cout;
    // Leaving RUN straight to DONE the MSB overflow is only visible combinationally.
    assign ovf_final = (state == S_RUN) ? ovf_now : ovf_q;

    assign ready      = (state == S_IDLE);
    assign done       = (state == S_DONE);
    assign slice_a    = (state == S_RUN) & a_q[idx];
    assign slice_b    = (state == S_RUN) & b_q[idx];
    assign slice_cin  = (state == S_RUN) & carry_q;
    assign slice_less = 1'b0;
    assign slice_op   = op_q;

    always_comb begin
        state_nx  = state;
        result_nx = result;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                result_nx[idx] = slice_result;
                if (idx == LAST_IDX)
                    state_nx = (op_q[1:0] == 2'b11) ? S_FIX : S_DONE;
            end
            S_FIX: begin
                // Sign of the difference corrected by overflow gives true signed less-than.
                result_nx = {{(WIDTH-1){1'b0}}, set_msb_q ^ ovf_q};
                state_nx  = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            set_msb_q <= 1'b0;
            ovf_q     <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state  <= state_nx;
            result <= result_nx;
            if (state == S_IDLE && start) begin
                a_q     <= a;
                b_q     <= b;
                op_q    <= op;
                carry_q <= op[2];
                idx     <= '0;
            end
            if (state == S_RUN) begin
                carry_q <= slice_cout;
                idx     <= is_last ? '0 : idx + 1'b1;
                if (is_last) begin
                    set_msb_q <= slice_set;
                    ovf_q     <= ovf_now;
                end
            end
            if (state_nx == S_DONE && state != S_DONE) begin
                zero     <= (result_nx == '0);
                overflow <= op_q[1] & ovf_final;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed self-checking bench with a behavioural 1-bit ALU slice.
`default_nettype none

module tb_alu_serial_ctrl;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             slice_a;
    logic             slice_b;
    logic             slice_cin;
    logic             slice_less;
    logic [3:0]       slice_op;
    logic             slice_result;
    logic             slice_cout;
    logic             slice_set;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_serial_ctrl #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
        .ready(ready), .done(done), .result(result), .zero(zero), .overflow(overflow),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_less(slice_less), .slice_op(slice_op),
        .slice_result(slice_result), .slice_cout(slice_cout), .slice_set(slice_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Classic 1-bit ALU slice with a/b inversion.
    logic sl_aa, sl_bb, sl_sum;
    always_comb begin
        sl_aa      = slice_a ^ slice_op[3];
        sl_bb      = slice_b ^ slice_op[2];
        sl_sum     = sl_aa ^ sl_bb ^ slice_cin;
        slice_cout = (sl_aa & sl_bb) | (sl_aa & slice_cin) | (sl_bb & slice_cin);
        slice_set  = sl_sum;
        case (slice_op[1:0])
            2'b00:   slice_result = sl_aa & sl_bb;
            2'b01:   slice_result = sl_aa | sl_bb;
            2'b10:   slice_result = sl_sum;
            default: slice_result = slice_less;
        endcase
    end

    task automatic wait_ready();
        for (int i = 0; i < 10 && !ready; i++) @(negedge clk);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                          input logic [3:0] opi, output logic [WIDTH-1:0] r,
                          output logic z, output logic o, output int cyc);
        @(negedge clk);
        wait_ready();
        a = ai; b = bi; op = opi; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
        r = result; z = zero; o = overflow;
    endtask

    task automatic test_reset();
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++; if ({zero, overflow, slice_a, slice_b, slice_cin, slice_less} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 000000",
                               {zero, overflow, slice_a, slice_b, slice_cin, slice_less});
        end
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] r; logic z, o; int c;
        run_op(32'h0000_0005, 32'h0000_0003, 4'b0010, r, z, o, c);
        n_cmp++; if (c !== 32) begin n_fail++; $display("FAIL add_latency got %0d want 32", c); end
        n_cmp++; if (r !== 32'h0000_0008) begin n_fail++; $display("FAIL add_result got %h want 00000008", r); end
        n_cmp++; if ({z, o} !== 2'b00) begin n_fail++; $display("FAIL add_flags got %b want 00", {z, o}); end
    endtask

    task automatic test_sub();
        logic [WIDTH-1:0] r; logic z, o; int c;
        run_op(32'h8000_0000, 32'h0000_0001, 4'b0110, r, z, o, c);
        n_cmp++; if (r !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sub_wrap_result got %h want 7fffffff", r); end
        n_cmp++; if ({z, o} !== 2'b01) begin n_fail++; $display("FAIL sub_wrap_flags got %b want 01", {z, o}); end
        run_op(32'h1234_5678, 32'h1234_5678, 4'b0110, r, z, o, c);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL sub_eq_result got %h want 00000000", r); end
        n_cmp++; if ({z, o} !== 2'b10) begin n_fail++; $display("FAIL sub_eq_flags got %b want 10", {z, o}); end
    endtask

    task automatic test_slt();
        logic [WIDTH-1:0] r; logic z, o; int c;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, r, z, o, c);
        n_cmp++; if (c !== 33) begin n_fail++; $display("FAIL slt_latency got %0d want 33", c); end
        n_cmp++; if (r !== 32'h1) begin n_fail++; $display("FAIL slt_neg_result got %h want 00000001", r); end
        n_cmp++; if ({z, o} !== 2'b00) begin n_fail++; $display("FAIL slt_neg_flags got %b want 00", {z, o}); end
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 4'b0111, r, z, o, c);
        n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL slt_ovf_result got %h want 00000000", r); end
        n_cmp++; if ({z, o} !== 2'b11) begin n_fail++; $display("FAIL slt_ovf_flags got %b want 11", {z, o}); end
    endtask

    task automatic test_logic();
        logic [WIDTH-1:0] r; logic z, o; int c;
        logic [3:0]       ops [4] = '{4'b0000, 4'b0001, 4'b1100, 4'b1101};
        logic [WIDTH-1:0] exp [4] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h000F_000F, 32'h0FFF_0FFF};
        for (int i = 0; i < 4; i++) begin
            run_op(32'hF0F0_F0F0, 32'hFF00_FF00, ops[i], r, z, o, c);
            n_cmp++;
            if (r !== exp[i] || {z, o} !== 2'b00) begin
                n_fail++;
                $display("FAIL logic_op%b got %h z%b o%b want %h z0 o0", ops[i], r, z, o, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  dones = 0;
        logic prev_done = 1'b0;
        @(negedge clk);
        wait_ready();
        a = 32'h5; b = 32'h3; op = 4'b0010; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 101; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) a = 32'h0000_FFFF;
            if (k == 20) a = 32'h5;
            if (done) begin
                dones++;
                n_cmp++;
                if (result !== 32'h8) begin n_fail++; $display("FAIL b2b_result got %h want 00000008", result); end
            end
            n_cmp++;
            if (done && prev_done) begin n_fail++; $display("FAIL b2b_pulse got 2-cycle done want 1-cycle"); end
            prev_done = done;
        end
        start = 1'b0;
        n_cmp++; if (dones !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", dones); end
    endtask

    task automatic test_reset_midop();
        logic [WIDTH-1:0] r; logic z, o; int c;
        @(negedge clk);
        wait_ready();
        a = 32'd100; b = 32'd23; op = 4'b0010; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({ready, done} !== 2'b10) begin n_fail++; $display("FAIL rstmid_hs got %b want 10", {ready, done}); end
        n_cmp++; if (result !== '0) begin n_fail++; $display("FAIL rstmid_result got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd100, 32'd23, 4'b0010, r, z, o, c);
        n_cmp++;
        if (r !== 32'd123 || c !== 32) begin
            n_fail++; $display("FAIL rstmid_after got %h in %0d want 0000007b in 32", r, c);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1 test_reset();
        @(negedge clk) rst_n = 1'b1;
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
